// File: rtl/selector_arb_nto1_pkg.sv
// Shared definitions for the N:1 registered selector: mode encoding and the
// channel-index width helper used by the interface, top and arbiter.
package selector_arb_nto1_pkg;

  typedef enum logic {
    SEL_MODE_FIXED = 1'b0,
    SEL_MODE_RR    = 1'b1
  } sel_mode_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/selector_arb_nto1_if.sv
// Valid/ready bundle between N request channels, the selector and one sink.
interface selector_arb_nto1_if
  import selector_arb_nto1_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = sel_width(N);

  logic [N-1:0]       InValid;
  logic [N-1:0]       InReady;
  logic [N*WIDTH-1:0] InData;
  logic               Mode;
  logic [SEL_W-1:0]   Control;
  logic               OutValid;
  logic               OutReady;
  logic [WIDTH-1:0]   OutData;
  logic [SEL_W-1:0]   OutSel;

  modport slave (
    input  InValid, InData, Mode, Control, OutReady,
    output InReady, OutValid, OutData, OutSel
  );

  modport master (
    output InValid, InData, Mode, Control, OutReady,
    input  InReady, OutValid, OutData, OutSel
  );

endinterface

// File: rtl/selector_arb_nto1_rr_arbiter.sv
// Combinational rotating-priority search: the requester closest to i_ptr
// (walking upward with wrap) wins.
module selector_arb_nto1_rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  input  logic             i_enable,
  output logic [N-1:0]     o_grant,
  output logic [SEL_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  int w_off;
  int w_best_off;

  // Pick the requester with the smallest rotated distance from the pointer.
  always_comb begin
    w_off         = 0;
    w_best_off    = N;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_off = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N - int'(i_ptr));
      if (i_enable && i_req[i] && (w_off < w_best_off)) begin
        w_best_off    = w_off;
        o_grant_idx   = SEL_W'(i);
        o_grant_valid = 1'b1;
      end else begin
        w_best_off    = w_best_off;
      end
    end
  end

  // One-hot view of the winning index.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = o_grant_valid && (o_grant_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/selector_arb_nto1.sv
// N-input selector with fixed or round-robin channel choice feeding a
// single-entry registered output stage with valid/ready on both sides.
module selector_arb_nto1
  import selector_arb_nto1_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic                clk,
  input logic                rst_n,
  selector_arb_nto1_if.slave io_bus
);

  localparam int SEL_W = sel_width(N);

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_sel;
  logic [SEL_W-1:0]   r_ptr;

  logic               w_load_en;
  logic               w_rr_en;
  logic [N-1:0]       w_arb_grant;
  logic [SEL_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic               w_fix_ok;
  logic [SEL_W-1:0]   w_grant_idx;
  logic [N-1:0]       w_sel_onehot;
  logic [N-1:0]       w_in_ready;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_data;

  assign w_load_en = !r_out_valid || io_bus.OutReady;
  assign w_rr_en   = (io_bus.Mode == SEL_MODE_RR);

  selector_arb_nto1_rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .i_req         (io_bus.InValid),
    .i_ptr         (r_ptr),
    .i_enable      (w_rr_en),
    .o_grant       (w_arb_grant),
    .o_grant_idx   (w_arb_idx),
    .o_grant_valid (w_arb_valid)
  );

  // Grant selection; an out-of-range Control in fixed mode grants nobody.
  always_comb begin
    w_fix_ok     = (N == 1) || (int'(io_bus.Control) < N);
    w_sel_onehot = '0;
    if (w_rr_en) begin
      w_grant_idx  = w_arb_idx;
      w_sel_onehot = w_arb_grant;
    end else begin
      w_grant_idx = (N == 1) ? '0 : io_bus.Control;
      for (int i = 0; i < N; i++) begin
        w_sel_onehot[i] = w_fix_ok && (w_grant_idx == SEL_W'(i));
      end
    end
  end

  assign w_in_ready = {N{rst_n && w_load_en}} & w_sel_onehot;
  assign w_xfer     = |(w_in_ready & io_bus.InValid);

  // Data slice of the granted channel.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        w_data = io_bus.InData[i*WIDTH +: WIDTH];
      end else begin
        w_data = w_data;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sel   <= w_grant_idx;
      end else if (io_bus.OutReady) begin
        r_out_valid <= 1'b0;
      end
      // Explicit wrap keeps the pointer legal for non-power-of-two N.
      if (w_xfer && w_rr_en) begin
        r_ptr <= (int'(w_grant_idx) == N - 1) ? '0 : w_grant_idx + SEL_W'(1);
      end
    end
  end

  assign io_bus.InReady  = w_in_ready;
  assign io_bus.OutValid = r_out_valid;
  assign io_bus.OutData  = r_out_data;
  assign io_bus.OutSel   = r_out_sel;

endmodule
